// File: rtl/button_debounce_if.sv
// button_debounce_if: bundles the tick/clear/button inputs and the
// debounced level and pulse outputs of button_debounce.
// The master modport drives the raw inputs. The slave modport is the debouncer side.
interface button_debounce_if #(
    parameter int unsigned NUM_BUTTONS = 2
);
    logic                   i_tick;
    logic                   i_clear;
    logic [NUM_BUTTONS-1:0] i_buttons;
    logic [NUM_BUTTONS-1:0] o_level;
    logic [NUM_BUTTONS-1:0] o_press_pulse;
    logic [NUM_BUTTONS-1:0] o_release_pulse;

    modport master (
        output i_tick,
        output i_clear,
        output i_buttons,
        input  o_level,
        input  o_press_pulse,
        input  o_release_pulse
    );

    modport slave (
        input  i_tick,
        input  i_clear,
        input  i_buttons,
        output o_level,
        output o_press_pulse,
        output o_release_pulse
    );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser plus one independent debounce FSM
// per button channel. The FSMs are timed by the i_tick pulse. Each channel
// produces a registered level and one-cycle press/release pulses.
// Optional feature macro: BUTTON_AUTOREPEAT_EN. When it is defined, a held
// button emits repeated press pulses.
module button_debounce #(
    parameter int unsigned NUM_BUTTONS    = 2,
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned REPEAT_DELAY   = 8,
    parameter int unsigned REPEAT_PERIOD  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debounce_if.slave    bus
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One counter width serves both the debounce and repeat counters (min 4 bits)
    localparam int unsigned CW = max_u(4, max_u($clog2(DEBOUNCE_TICKS + 1),
                                       max_u($clog2(REPEAT_DELAY + 1),
                                             $clog2(REPEAT_PERIOD + 1))));

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.i_buttons;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          s;
`ifdef BUTTON_AUTOREPEAT_EN
        logic [CW-1:0] rep_q, rep_d;
`endif

        assign s = sync2_q[g];

        // State, counters and registered outputs of this channel
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                rep_q     <= '0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef BUTTON_AUTOREPEAT_EN
                rep_q     <= rep_d;
`endif
            end
        end

        // Next-state logic. A sync-level change beats a tick, and clear beats everything
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_d     = rep_q;
`endif
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CW'(DEBOUNCE_TICKS);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (bus.i_tick) begin
                        if (cnt_q == CW'(1)) begin
                            state_d = PRESSED;
                            press_d = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                            rep_d   = CW'(REPEAT_DELAY);
`endif
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CW'(DEBOUNCE_TICKS);
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (bus.i_tick) begin
                        if (rep_q == CW'(1)) begin
                            press_d = 1'b1;
                            rep_d   = CW'(REPEAT_PERIOD);
                        end else begin
                            rep_d = rep_q - 1'b1;
                        end
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_d = PRESSED;
`ifdef BUTTON_AUTOREPEAT_EN
                        rep_d   = CW'(REPEAT_PERIOD);
`endif
                    end else if (bus.i_tick) begin
                        if (cnt_q == CW'(1)) begin
                            state_d   = IDLE;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (bus.i_clear) begin
                state_d   = IDLE;
                press_d   = 1'b0;
                release_d = 1'b0;
            end

            level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        end

        assign bus.o_level[g]         = level_q;
        assign bus.o_press_pulse[g]   = press_q;
        assign bus.o_release_pulse[g] = release_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed self-checking bench for button_debounce
// (NUM_BUTTONS=2, DEBOUNCE_TICKS=3, REPEAT_DELAY=8, REPEAT_PERIOD=4).
// Expected repeat behaviour follows BUTTON_AUTOREPEAT_EN when it is defined.
module tb_button_debounce;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int   press_cnt0 = 0;
    int   press_cnt1 = 0;
    int   rel_cnt0   = 0;
    int   rel_cnt1   = 0;
    logic cnt_clr    = 1'b1;

    button_debounce_if #(.NUM_BUTTONS(2)) bus ();

    button_debounce #(
        .NUM_BUTTONS   (2),
        .DEBOUNCE_TICKS(3),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (cnt_clr) begin
            press_cnt0 = 0;
            press_cnt1 = 0;
            rel_cnt0   = 0;
            rel_cnt1   = 0;
        end else begin
            if (bus.o_press_pulse[0] === 1'b1)   press_cnt0++;
            if (bus.o_press_pulse[1] === 1'b1)   press_cnt1++;
            if (bus.o_release_pulse[0] === 1'b1) rel_cnt0++;
            if (bus.o_release_pulse[1] === 1'b1) rel_cnt1++;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            bus.i_tick = 1'b1;
            cyc(1);
            bus.i_tick = 1'b0;
        end
    endtask

    task automatic clr_counts();
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
    endtask

    task automatic check2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Release the channels in mask from an accepted state, checking the release pulse
    task automatic release_and_check(input string tag, input logic [1:0] mask);
        bus.i_buttons = bus.i_buttons & ~mask;
        cyc(4);
        do_tick(2);
        check2({tag, "_lvl_hold"}, bus.o_level & mask, mask);
        do_tick(1);
        check2({tag, "_lvl_off"}, bus.o_level & mask, 2'b00);
        check2({tag, "_rel"}, bus.o_release_pulse, mask);
        cyc(1);
        check2({tag, "_rel_end"}, bus.o_release_pulse, 2'b00);
    endtask

    initial begin
        bus.i_tick    = 1'b0;
        bus.i_clear   = 1'b0;
        bus.i_buttons = 2'b11;
        rst_n         = 1'b0;

        // Reset with both buttons held
        cyc(3);
        check2("rst_level", bus.o_level, 2'b00);
        check2("rst_press", bus.o_press_pulse, 2'b00);
        check2("rst_release", bus.o_release_pulse, 2'b00);
        rst_n = 1'b1;
        clr_counts();
        for (int k = 1; k <= 3; k++) begin
            cyc(15);
            do_tick(1);
            check2("t1_level", bus.o_level, (k < 3) ? 2'b00 : 2'b11);
        end
        check2("t1_press", bus.o_press_pulse, 2'b11);
        cyc(1);
        check2("t1_press_end", bus.o_press_pulse, 2'b00);
        check2("t1_level_hold", bus.o_level, 2'b11);
        checki("t1_press_cnt0", press_cnt0, 1);
        checki("t1_press_cnt1", press_cnt1, 1);
        release_and_check("t1", 2'b11);
        cyc(1);

        // Bounce on button0 during PRESS_WAIT restarts the debounce
        clr_counts();
        bus.i_buttons = 2'b01;
        cyc(4);
        do_tick(2);
        bus.i_buttons = 2'b00;
        cyc(1);
        bus.i_buttons = 2'b01;
        cyc(4);
        check2("t2_level_a", bus.o_level, 2'b00);
        do_tick(2);
        check2("t2_level_b", bus.o_level, 2'b00);
        do_tick(1);
        check2("t2_level_c", bus.o_level, 2'b01);
        check2("t2_press", bus.o_press_pulse, 2'b01);
        cyc(2);
        checki("t2_press_cnt0", press_cnt0, 1);
        checki("t2_press_cnt1", press_cnt1, 0);

        // Release glitch across 2 ticks keeps the level, then a real release
        clr_counts();
        bus.i_buttons = 2'b00;
        cyc(4);
        do_tick(2);
        bus.i_buttons = 2'b01;
        cyc(4);
        check2("t3_level_kept", bus.o_level, 2'b01);
        checki("t3_rel_cnt0", rel_cnt0, 0);
        checki("t3_press_cnt0", press_cnt0, 0);
        release_and_check("t3", 2'b01);
        cyc(1);

        // Clear while held: level drops, no release, full re-debounce
        bus.i_buttons = 2'b01;
        cyc(4);
        do_tick(3);
        check2("t4_pre_level", bus.o_level, 2'b01);
        cyc(2);
        clr_counts();
        bus.i_clear = 1'b1;
        cyc(1);
        bus.i_clear = 1'b0;
        check2("t4_clr_level", bus.o_level, 2'b00);
        check2("t4_clr_rel", bus.o_release_pulse, 2'b00);
        cyc(1);
        do_tick(2);
        check2("t4_redeb_wait", bus.o_level, 2'b00);
        do_tick(1);
        check2("t4_redeb_level", bus.o_level, 2'b01);
        check2("t4_redeb_press", bus.o_press_pulse, 2'b01);
        checki("t4_rel_cnt0", rel_cnt0, 0);
        release_and_check("t4", 2'b01);
        cyc(1);

        // Tick in the PRESS_WAIT entry cycle is not counted
        bus.i_buttons = 2'b01;
        cyc(2);
        do_tick(1);
        do_tick(2);
        check2("t5_entry_tick", bus.o_level, 2'b00);
        do_tick(1);
        check2("t5_accept", bus.o_level, 2'b01);
        check2("t5_press", bus.o_press_pulse, 2'b01);
        release_and_check("t5", 2'b01);
        cyc(1);

        // Tick together with s=0 in PRESS_WAIT returns to IDLE
        clr_counts();
        bus.i_buttons = 2'b01;
        cyc(4);
        do_tick(2);
        bus.i_buttons = 2'b00;
        cyc(2);
        do_tick(1);
        check2("t5b_level", bus.o_level, 2'b00);
        check2("t5b_press", bus.o_press_pulse, 2'b00);
        cyc(2);
        checki("t5b_press_cnt0", press_cnt0, 0);

        // Clear coinciding with the accepting tick suppresses the press
        bus.i_buttons = 2'b01;
        cyc(4);
        do_tick(2);
        bus.i_clear = 1'b1;
        do_tick(1);
        bus.i_clear = 1'b0;
        check2("t6_clr_level", bus.o_level, 2'b00);
        check2("t6_clr_press", bus.o_press_pulse, 2'b00);
        cyc(1);
        do_tick(2);
        check2("t6_wait", bus.o_level, 2'b00);
        do_tick(1);
        check2("t6_level", bus.o_level, 2'b01);
        check2("t6_press", bus.o_press_pulse, 2'b01);
        release_and_check("t6", 2'b01);
        cyc(1);

        // Both held with continuous ticks: simultaneous accept, then repeats if enabled
        bus.i_buttons = 2'b11;
        cyc(4);
        clr_counts();
        bus.i_tick = 1'b1;
        cyc(2);
        check2("t7_wait", bus.o_level, 2'b00);
        cyc(1);
        check2("t7_level", bus.o_level, 2'b11);
        check2("t7_press0", bus.o_press_pulse, 2'b11);
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            check2($sformatf("t7_rep%0d", i), bus.o_press_pulse,
                   (AUTOREP && (i == 8 || i == 12 || i == 16 || i == 20)) ? 2'b11 : 2'b00);
        end
        bus.i_tick = 1'b0;
        cyc(1);
        checki("t7_press_cnt0", press_cnt0, AUTOREP ? 5 : 1);
        checki("t7_press_cnt1", press_cnt1, AUTOREP ? 5 : 1);
        release_and_check("t7", 2'b11);
        cyc(2);
        checki("t7_rel_cnt0", rel_cnt0, 1);
        checki("t7_rel_cnt1", rel_cnt1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions raw push-button/pin inputs before they reach player_controller.
- Synchronises each input, debounces it against the vpos-bit-5 rising-edge pulse (debounce_countdown_en) from graphics_top, and produces clean levels plus one-cycle press/release pulses.
- Sits between ui_in/gamepad decode and player_controller/ai_controller.

Parameters:
- NUM_BUTTONS, 2, number of independent button channels.
- DEBOUNCE_TICKS, 3, consecutive i_tick pulses an input must stay stable to be accepted; legal range 1..15.
- REPEAT_DELAY, 8, i_tick pulses held before the first auto-repeat pulse (only with BUTTON_AUTOREPEAT_EN).
- REPEAT_PERIOD, 4, i_tick pulses between later auto-repeat pulses (only with BUTTON_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- i_tick  input  1  debounce time-base pulse, one clk wide (debounce_countdown_en).
- i_clear  input  1  synchronous clear, e.g. game_start_pulse.
- i_buttons  input  NUM_BUTTONS  raw asynchronous button levels, active-high.
- o_level  output  NUM_BUTTONS  debounced level per button.
- o_press_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted press (and auto-repeat).
- o_release_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted release.

Behaviour:
- Reset value of all outputs, sync flops, FSMs and counters: 0 / IDLE.
- Synchroniser: two flops per bit. The sampled value s is the second-flop output, 2 clk after the raw edge.
- Each channel runs an independent FSM with a counter of at least 4 bits.
- States and transitions:
  - IDLE: o_level=0. If s=1, go to PRESS_WAIT and load cnt=DEBOUNCE_TICKS.
  - PRESS_WAIT: o_level=0.
    - If s=0, return to IDLE; this is bounce rejection and has priority over a tick in the same cycle.
    - Else on i_tick, decrement cnt.
    - A tick with cnt==1 goes to PRESSED.
  - PRESSED: o_level=1. If s=0, go to RELEASE_WAIT and load cnt=DEBOUNCE_TICKS.
  - RELEASE_WAIT: o_level=1.
    - If s=1, return to PRESSED, with no pulses.
    - Else on i_tick, decrement cnt.
    - A tick with cnt==1 goes to IDLE.
- A tick in the same cycle as the state entry/counter load is not counted.
- Outputs are registered:
  - o_level changes in the first cycle the new state is held.
  - o_press_pulse is high exactly in the first cycle of PRESSED entered from PRESS_WAIT.
  - o_release_pulse is high exactly in the first cycle of IDLE entered from RELEASE_WAIT.
- i_clear:
  - All channels go to IDLE next cycle and o_level goes to 0.
  - No release pulse is generated, and pulses scheduled that cycle are suppressed.
  - A button still held is re-debounced from IDLE (full DEBOUNCE_TICKS).
  - i_clear has priority over all other events.
- Channels never interact. Simultaneous presses on different channels produce pulses in the same cycle.
- i_tick held high continuously is legal: each clk with i_tick=1 counts as one tick.

Optional Feature:
- Macro BUTTON_AUTOREPEAT_EN.
- Defined:
  - While in PRESSED, a repeat counter loads REPEAT_DELAY on entry and decrements per i_tick.
  - When it expires, o_press_pulse fires one cycle and the counter reloads REPEAT_PERIOD.
  - Leaving PRESSED, or entering RELEASE_WAIT, stops repeats. Returning from RELEASE_WAIT to PRESSED resumes with REPEAT_PERIOD.
- Undefined: no repeat counter is synthesised, and exactly one press pulse is produced per accepted press.

Test Plan:
- Reset with i_buttons=2'b11 held, then release rst_n with ticks every 16 clk -> o_level stays 0 until 3 ticks after s=1; then o_level[1:0]=11 and o_press_pulse=11 for one cycle.
- Bounce: button0 high for 2 ticks, low 1 clk, high again -> FSM restarts; press pulse only after 3 further ticks, with exactly one pulse total.
- Release glitch: button0 held and accepted, drop low across 2 ticks, return high -> o_level stays 1, no release or press pulses; a later stable low for 3 ticks -> o_release_pulse one cycle, o_level=0.
- i_clear asserted while o_level=01 and button held -> o_level=00 next cycle, no release pulse; a new press pulse follows 3 ticks later.
- Tick coincident with the state-entry cycle -> not counted (acceptance needs 3 further ticks); tick coincident with s=0 in PRESS_WAIT -> returns to IDLE.
- With BUTTON_AUTOREPEAT_EN, DEBOUNCE_TICKS=3, REPEAT_DELAY=8, REPEAT_PERIOD=4, hold 20 ticks past acceptance -> press pulses at ticks 0, 8, 12, 16, 20 after acceptance. Without the macro -> one pulse only.
